pwm_ctrl: RTL and testbench
===========================

# pwm_ctrl

Memory-mapped controller that configures the PWM channel array of the demo system from software. It replaces the fixed switch-driven pulse widths with per-channel compare values and a shared period, and it hangs off the system bus as a 4 KiB device. Software writes shadow registers. The controller applies them atomically at a PWM period boundary, so channels never glitch mid-period. It keeps a mirror period counter that is lock-step with the `pwm` instances: both reset together, and both count 0..max_counter inclusive, then wrap.

## Interface
- `NumCh`, 12: number of PWM channels, range 1..60.
- `CtrSize`, 8: width of the PWM counter, compare and period values, range 1..32.
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset, asynchronous and active-high.
- `device_req_i`  in  1  bus request; a single-cycle access.
- `device_addr_i`  in  32  byte address; only `[11:2]` are decoded.
- `device_we_i`  in  1  write enable.
- `device_be_i`  in  4  byte enables for writes.
- `device_wdata_i`  in  32  write data.
- `device_rvalid_o`  out  1  response valid.
- `device_rdata_o`  out  32  read data.
- `device_err_o`  out  1  error response, qualified by `device_rvalid_o`.
- `pulse_width_o`  out  NumCh*CtrSize  active compare value; channel i occupies `[i*CtrSize +: CtrSize]`.
- `max_counter_o`  out  CtrSize  active period value.
- `pwm_en_o`  out  1  channels enabled.
- `period_o`  out  1  one-cycle pulse on the last count of each period.

## Operation
Register map (word offsets):
- 0x000 CTRL
  - bit0 EN, read/write.
  - bit1 UPD, write 1 to request a commit; reads back as pending.
  - Writing 0 to UPD has no effect.
- 0x004 MAX_SH: shadow period, `[CtrSize-1:0]`.
- 0x008 STATUS, read-only.
  - bit0 pending.
  - `[31:16]` period count, incremented on each `period_o`. It wraps at 0xFFFF and clears when EN falls.
- 0x00C MAX_ACT, read-only: active period.
- 0x010 + 4*i WIDTH_SH[i], for i < NumCh: shadow compare value.

Access rules:
- Unused register bits read as 0.
- Writes honour `device_be_i` per byte.
- Bits above `CtrSize` are dropped.
- An access to any unmapped offset returns `device_err_o`=1 and rdata 0. A write to an unmapped offset is discarded.
- A write to a read-only register is ignored with no error.

Mirror counter `ctr`:
- While EN=0, `ctr` is held at 0.
- While EN=1, `ctr` increments each cycle. At `ctr`==MAX_ACT it wraps to 0.
- `period_o` = EN && `ctr`==MAX_ACT.

Commit:
- The commit condition is pending && (EN=0 || `ctr`==MAX_ACT).
- On a commit cycle, all WIDTH_SH are copied to active and MAX_SH to MAX_ACT, and pending clears, all at the next clock edge.
- `ctr` wraps to 0 on the same edge, so the new period starts with the new values.
- The copy uses shadow values from before that cycle's edge. A shadow write in the same cycle lands in shadow only.
- A CTRL write with UPD=1 in the commit cycle leaves pending set. A fresh commit then follows at the next boundary.

Outputs:
- `pulse_width_o` shows the active values when EN=1 and is forced to 0 when EN=0.
- `max_counter_o` always shows MAX_ACT.
- `pwm_en_o` = EN.

## Timing
- Reset values:
  - All registers are 0.
  - `ctr`=0.
  - All outputs are 0, including `device_rvalid_o`, `device_err_o`, `device_rdata_o`, `pulse_width_o`, `max_counter_o`, `pwm_en_o` and `period_o`.
- Bus:
  - The device never stalls; every request is accepted.
  - `device_rvalid_o` rises exactly 1 cycle after `device_req_i` and lasts 1 cycle.
  - `device_rdata_o` and `device_err_o` are valid with it and are 0 otherwise.
  - Write responses carry rdata 0.
  - Back-to-back requests give back-to-back rvalids.
- A register write is visible to a read issued the following cycle.
- Setting EN starts counting on the next edge: `ctr`=1 one cycle after EN reads 1.
- With EN=0, a commit lands 1 cycle after the UPD write, so outputs change 2 edges after the request.
- With EN=1, a commit lands on the edge following the cycle where `ctr`==MAX_ACT. The worst case is MAX_ACT+1 cycles after the request.
- With MAX_ACT=0, every cycle is a boundary and `period_o` stays high.
- Asserting `rst_i` at any time, including mid-period or with pending set, clears all state asynchronously. No commit is performed.

## Test plan
- Reset → all outputs 0. Reads of CTRL, MAX_SH, STATUS, MAX_ACT and WIDTH_SH[0] → 0. `device_rvalid_o` high 1 cycle after each request.
- EN=0. Write WIDTH_SH[0]=0x40 and MAX_SH=0xFF, then CTRL=0x2 → MAX_ACT=0xFF two edges later. `pulse_width_o` stays 0. Write CTRL=0x1 → channel 0 shows 0x40.
- EN=1, MAX_ACT=0x0F.
  - Write WIDTH_SH[3]=0x05 with UPD=1 when `ctr`=3 → pending=1 until the edge after `ctr`==0x0F. Channel 3 then changes to 0x05.
  - `period_o` pulses every 16 cycles. The STATUS count increments once per pulse.
- During a pending update, rewrite WIDTH_SH[1] twice (0x11 then 0x22) → 0x22 committed. A shadow write in the commit cycle (0x33) stays in shadow; active keeps 0x22.
- Byte enables: write 0xAABBCCDD to WIDTH_SH[2] with be=0b0001 (CtrSize 8) → reads back 0xDD. Write with be=0b0010 → unchanged.
- Access offset 0x010+4*NumCh and 0xFFC → `device_err_o`=1 with rvalid and rdata 0. No register changes. Assert `rst_i` with pending=1 mid-period → everything returns to 0.

Source files
------------

// File: rtl/pwm_ctrl.sv
// pwm_ctrl: bus-mapped configuration block for the PWM channel array.
// Software writes shadow registers. They are copied to the active set at a
// period boundary of a mirror counter that runs in lock-step with the pwm cores.
module pwm_ctrl #(
  parameter int NumCh   = 12,
  parameter int CtrSize = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     device_req_i,
  input  logic [31:0]              device_addr_i,
  input  logic                     device_we_i,
  input  logic [3:0]               device_be_i,
  input  logic [31:0]              device_wdata_i,
  output logic                     device_rvalid_o,
  output logic [31:0]              device_rdata_o,
  output logic                     device_err_o,
  output logic [NumCh*CtrSize-1:0] pulse_width_o,
  output logic [CtrSize-1:0]       max_counter_o,
  output logic                     pwm_en_o,
  output logic                     period_o
);

  localparam logic [9:0] WidthBase = 10'd4;
  localparam logic [9:0] WidthEnd  = 10'(4 + NumCh);

  // Byte-lane merge of a write into a CtrSize-wide register; lanes above CtrSize fall away.
  function automatic logic [CtrSize-1:0] be_merge(input logic [CtrSize-1:0] old_val,
                                                  input logic [CtrSize-1:0] new_val,
                                                  input logic [3:0]         be);
    logic [CtrSize-1:0] res;
    for (int k = 0; k < CtrSize; k++) begin
      res[k] = be[k / 8] ? new_val[k] : old_val[k];
    end
    return res;
  endfunction

  logic [9:0]         word_idx;
  logic [9:0]         width_idx;
  logic               is_ctrl, is_max_sh, is_status, is_max_act, is_width, mapped;
  logic               wr_en, ctrl_wr, en_next, upd_req, boundary, commit;
  logic               en_reg, pending_reg;
  logic [CtrSize-1:0] ctr_reg, max_sh_reg, max_act_reg;
  logic [15:0]        pcount_reg;
  logic [CtrSize-1:0] width_sh  [NumCh];
  logic [CtrSize-1:0] width_act [NumCh];
  logic [31:0]        rd_value;
  logic               rvalid_reg, err_reg;
  logic [31:0]        rdata_reg;
  logic               unused_bits;

  // Only the word offset within the 4 KiB window is decoded.
  assign word_idx    = device_addr_i[11:2];
  assign width_idx   = word_idx - WidthBase;
  assign is_ctrl     = (word_idx == 10'd0);
  assign is_max_sh   = (word_idx == 10'd1);
  assign is_status   = (word_idx == 10'd2);
  assign is_max_act  = (word_idx == 10'd3);
  assign is_width    = (word_idx >= WidthBase) && (word_idx < WidthEnd);
  assign mapped      = is_ctrl || is_max_sh || is_status || is_max_act || is_width;
  assign unused_bits = ^{device_addr_i[31:12], device_addr_i[1:0], device_wdata_i, device_be_i};

  // EN and UPD both live in byte lane 0 of CTRL.
  assign wr_en    = device_req_i && device_we_i;
  assign ctrl_wr  = wr_en && is_ctrl && device_be_i[0];
  assign en_next  = ctrl_wr ? device_wdata_i[0] : en_reg;
  assign upd_req  = ctrl_wr && device_wdata_i[1];

  // A boundary is the last count of a period; with EN low any cycle may commit.
  assign boundary = en_reg && (ctr_reg == max_act_reg);
  assign commit   = pending_reg && (!en_reg || boundary);

  // Control state: enable, pending flag, mirror counter and period count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_reg      <= 1'b0;
      pending_reg <= 1'b0;
      ctr_reg     <= '0;
      pcount_reg  <= '0;
    end else begin
      en_reg <= en_next;
      // A new request in the commit cycle wins over the clear.
      if (upd_req) begin
        pending_reg <= 1'b1;
      end else if (commit) begin
        pending_reg <= 1'b0;
      end
      ctr_reg    <= (en_reg && en_next && !boundary) ? ctr_reg + 1'b1 : '0;
      pcount_reg <= !en_next ? 16'd0 : (boundary ? pcount_reg + 16'd1 : pcount_reg);
    end
  end

  // Shadow and active period registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      max_sh_reg  <= '0;
      max_act_reg <= '0;
    end else begin
      if (wr_en && is_max_sh) begin
        max_sh_reg <= be_merge(max_sh_reg, device_wdata_i[CtrSize-1:0], device_be_i);
      end
      if (commit) begin
        max_act_reg <= max_sh_reg;
      end
    end
  end

  // Shadow compare values take bus writes; active values load from shadow on commit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumCh; i++) begin
        width_sh[i]  <= '0;
        width_act[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumCh; i++) begin
        if (wr_en && is_width && (width_idx == 10'(i))) begin
          width_sh[i] <= be_merge(width_sh[i], device_wdata_i[CtrSize-1:0], device_be_i);
        end
        if (commit) begin
          width_act[i] <= width_sh[i];
        end
      end
    end
  end

  // Read data selection for the addressed register.
  always_comb begin
    rd_value = '0;
    if (is_ctrl) begin
      rd_value = {30'd0, pending_reg, en_reg};
    end else if (is_max_sh) begin
      rd_value = 32'(max_sh_reg);
    end else if (is_status) begin
      rd_value = {pcount_reg, 15'd0, pending_reg};
    end else if (is_max_act) begin
      rd_value = 32'(max_act_reg);
    end else if (is_width) begin
      for (int i = 0; i < NumCh; i++) begin
        if (width_idx == 10'(i)) begin
          rd_value = 32'(width_sh[i]);
        end
      end
    end
  end

  // Single-cycle bus response, one cycle after each request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_reg <= 1'b0;
      err_reg    <= 1'b0;
      rdata_reg  <= '0;
    end else begin
      rvalid_reg <= device_req_i;
      err_reg    <= device_req_i && !mapped;
      rdata_reg  <= (device_req_i && !device_we_i && mapped) ? rd_value : 32'd0;
    end
  end

  assign device_rvalid_o = rvalid_reg;
  assign device_err_o    = err_reg;
  assign device_rdata_o  = rdata_reg;
  assign max_counter_o   = max_act_reg;
  assign pwm_en_o        = en_reg;
  assign period_o        = boundary;

  // Disabled channels see a zero compare value.
  for (genvar gi = 0; gi < NumCh; gi++) begin : g_pulse
    assign pulse_width_o[gi*CtrSize +: CtrSize] = en_reg ? width_act[gi] : '0;
  end

endmodule

// File: tb/tb_pwm_ctrl.sv
// tb_pwm_ctrl: directed register-map vectors, hand-written commit sequences and
// random bus traffic, all checked against a cycle-level behavioural model.
module tb_pwm_ctrl;

  localparam int NumCh   = 12;
  localparam int CtrSize = 8;
  localparam int PW      = NumCh * CtrSize;
  localparam int unsigned Mask = (32'd1 << CtrSize) - 32'd1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          device_req = 1'b0;
  logic [31:0]   device_addr = '0;
  logic          device_we = 1'b0;
  logic [3:0]    device_be = '0;
  logic [31:0]   device_wdata = '0;
  logic          device_rvalid;
  logic [31:0]   device_rdata;
  logic          device_err;
  logic [PW-1:0] pulse_width;
  logic [CtrSize-1:0] max_counter;
  logic          pwm_en;
  logic          period;

  always #5 clk = ~clk;

  pwm_ctrl #(.NumCh(NumCh), .CtrSize(CtrSize)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .device_req_i   (device_req),
    .device_addr_i  (device_addr),
    .device_we_i    (device_we),
    .device_be_i    (device_be),
    .device_wdata_i (device_wdata),
    .device_rvalid_o(device_rvalid),
    .device_rdata_o (device_rdata),
    .device_err_o   (device_err),
    .pulse_width_o  (pulse_width),
    .max_counter_o  (max_counter),
    .pwm_en_o       (pwm_en),
    .period_o       (period)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_en, m_pend;
  int unsigned m_ctr, m_msh, m_mact, m_pcnt;
  int unsigned m_ws [NumCh];
  int unsigned m_wa [NumCh];

  task automatic model_reset();
    m_en = 0; m_pend = 0; m_ctr = 0; m_msh = 0; m_mact = 0; m_pcnt = 0;
    for (int i = 0; i < NumCh; i++) begin
      m_ws[i] = 0;
      m_wa[i] = 0;
    end
  endtask

  function automatic int unsigned merge(input int unsigned old, input logic [31:0] wd, input logic [3:0] be);
    int unsigned r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r & Mask;
  endfunction

  function automatic logic [31:0] model_read(input int unsigned off);
    if (off == 0)  return {30'd0, m_pend, m_en};
    if (off == 4)  return m_msh;
    if (off == 8)  return {m_pcnt[15:0], 15'd0, m_pend};
    if (off == 12) return m_mact;
    return m_ws[(off - 16) / 4];
  endfunction

  // One clock edge of the specified behaviour: response from the state before
  // the edge, then the register, counter and commit effects of that edge.
  task automatic model_step(input bit req, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            output bit ev, output logic [31:0] erd, output bit eerr);
    bit en0, pend0, new_en, upd, is_boundary, do_commit, mapped;
    int unsigned ctr0, mact0, msh0, off;
    int unsigned ws0 [NumCh];
    en0 = m_en; pend0 = m_pend; new_en = m_en; upd = 0;
    ctr0 = m_ctr; mact0 = m_mact; msh0 = m_msh; ws0 = m_ws;
    off = {20'd0, addr[11:2], 2'b00};
    mapped = off < 16 + 4 * NumCh;
    is_boundary = en0 && (ctr0 == mact0);
    do_commit   = pend0 && (!en0 || is_boundary);
    ev = req; erd = '0; eerr = 0;
    if (req && !mapped) begin
      eerr = 1;
    end else if (req && !we) begin
      erd = model_read(off);
    end else if (req && we) begin
      if (off == 0) begin
        if (be[0]) begin
          new_en = wdata[0];
          upd    = wdata[1];
        end
      end else if (off == 4) begin
        m_msh = merge(m_msh, wdata, be);
      end else if (off >= 16) begin
        m_ws[(off - 16) / 4] = merge(m_ws[(off - 16) / 4], wdata, be);
      end
    end
    if (do_commit) begin
      m_mact = msh0;
      m_wa   = ws0;
    end
    m_pend = upd ? 1'b1 : (do_commit ? 1'b0 : pend0);
    m_ctr  = en0 ? ((ctr0 == mact0) ? 0 : ctr0 + 1) : 0;
    if (en0 && !new_en)   m_pcnt = 0;
    else if (is_boundary) m_pcnt = (m_pcnt + 1) & 32'hFFFF;
    m_en = new_en;
  endtask

  function automatic logic [PW-1:0] exp_pulse();
    logic [PW-1:0] v;
    v = '0;
    for (int i = 0; i < NumCh; i++) if (m_en) v[i*CtrSize +: CtrSize] = m_wa[i][CtrSize-1:0];
    return v;
  endfunction

  // ---------------- bus driver ----------------
  // Called #1 after a rising edge; drives one cycle and checks all outputs after the edge.
  task automatic cycle(input bit req, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       output logic [31:0] rd, output logic er);
    bit ev, eerr;
    logic [31:0] erd;
    device_req = req; device_we = we; device_addr = addr; device_wdata = wdata; device_be = be;
    model_step(req, we, addr, wdata, be, ev, erd, eerr);
    @(posedge clk);
    #1;
    check("rvalid", PW'(device_rvalid), PW'(ev));
    check("rdata", PW'(device_rdata), PW'(erd));
    check("err", PW'(device_err), PW'(eerr));
    check("pulse_width", pulse_width, exp_pulse());
    check("max_counter", PW'(max_counter), PW'(m_mact[CtrSize-1:0]));
    check("pwm_en", PW'(pwm_en), PW'(m_en));
    check("period", PW'(period), PW'(m_en && (m_ctr == m_mact)));
    rd = device_rdata;
    er = device_err;
    device_req = 1'b0;
    device_we  = 1'b0;
  endtask

  task automatic idle();
    logic [31:0] d; logic e;
    cycle(0, 0, 32'd0, 32'd0, 4'h0, d, e);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d; logic e;
    cycle(1, 1, addr, data, 4'hF, d, e);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    logic e;
    cycle(1, 0, addr, 32'd0, 4'hF, data, e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rvalid"}, PW'(device_rvalid), '0);
    check({tag, "_rdata"}, PW'(device_rdata), '0);
    check({tag, "_err"}, PW'(device_err), '0);
    check({tag, "_pulse"}, pulse_width, '0);
    check({tag, "_maxc"}, PW'(max_counter), '0);
    check({tag, "_en"}, PW'(pwm_en), '0);
    check({tag, "_period"}, PW'(period), '0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, input logic [31:0] exp_rdata, input bit exp_err);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.be = be; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic e;
    int n;
    int pulses;
    int sel;
    bit rwe;
    logic [11:0] off;
    logic [31:0] tmp, addr, wdata;
    logic [3:0]  be;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Reset values, register write/readback, byte enables, unmapped and read-only accesses.
    add(0, 32'h000, 32'h0, 4'hF, 32'h0, 0);
    add(0, 32'h004, 32'h0, 4'hF, 32'h0, 0);
    add(0, 32'h008, 32'h0, 4'hF, 32'h0, 0);
    add(0, 32'h00C, 32'h0, 4'hF, 32'h0, 0);
    add(0, 32'h010, 32'h0, 4'hF, 32'h0, 0);
    add(1, 32'h010, 32'h40, 4'hF, 32'h0, 0);
    add(1, 32'h004, 32'hFF, 4'hF, 32'h0, 0);
    add(0, 32'h010, 32'h0, 4'hF, 32'h40, 0);
    add(0, 32'h004, 32'h0, 4'hF, 32'hFF, 0);
    add(1, 32'h018, 32'hAABBCCDD, 4'b0001, 32'h0, 0);
    add(0, 32'h018, 32'h0, 4'hF, 32'hDD, 0);
    add(1, 32'h018, 32'h11223344, 4'b0010, 32'h0, 0);
    add(0, 32'h018, 32'h0, 4'hF, 32'hDD, 0);
    add(0, 32'h010 + 4 * NumCh, 32'h0, 4'hF, 32'h0, 1);
    add(1, 32'h010 + 4 * NumCh, 32'hFFFFFFFF, 4'hF, 32'h0, 1);
    add(0, 32'hFFC, 32'h0, 4'hF, 32'h0, 1);
    add(1, 32'hFFC, 32'hFFFFFFFF, 4'hF, 32'h0, 1);
    add(1, 32'h00C, 32'h55, 4'hF, 32'h0, 0);
    add(0, 32'h00C, 32'h0, 4'hF, 32'h0, 0);
    add(1, 32'h008, 32'hFFFFFFFF, 4'hF, 32'h0, 0);
    add(0, 32'h008, 32'h0, 4'hF, 32'h0, 0);
    add(1, 32'h03C, 32'h1FF, 4'hF, 32'h0, 0);
    add(0, 32'h03C, 32'h0, 4'hF, 32'hFF, 0);
    add(0, 32'h000, 32'h0, 4'hF, 32'h0, 0);
    add(0, 32'h1000_0010, 32'h0, 4'hF, 32'h40, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(1, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, r, e);
      check($sformatf("vec%0d_rdata", i), PW'(r), PW'(vecs[i].exp_rdata));
      check($sformatf("vec%0d_err", i), PW'(e), PW'(vecs[i].exp_err));
    end

    // Commit with EN=0 lands one cycle after the UPD write.
    wr(32'h000, 32'h2);
    check("max_before_commit", PW'(max_counter), PW'(8'h00));
    rd(32'h000, r);
    check("ctrl_pending_en0", PW'(r), PW'(32'h2));
    check("max_after_commit", PW'(max_counter), PW'(8'hFF));
    check("pulse_zero_en0", pulse_width, '0);
    wr(32'h000, 32'h1);
    check("ch0_enabled", PW'(pulse_width[7:0]), PW'(8'h40));
    check("ch2_enabled", PW'(pulse_width[23:16]), PW'(8'hDD));
    check("ch11_enabled", PW'(pulse_width[95:88]), PW'(8'hFF));

    // Period 16: UPD issued at ctr=4 commits after the cycle with ctr=15.
    wr(32'h000, 32'h0);
    wr(32'h004, 32'h0F);
    wr(32'h000, 32'h2);
    idle();
    check("max_0f", PW'(max_counter), PW'(8'h0F));
    wr(32'h000, 32'h1);
    repeat (3) idle();
    wr(32'h01C, 32'h05);
    wr(32'h000, 32'h3);
    n = 0;
    while (n < 40 && pulse_width[31:24] != 8'h05) begin
      idle();
      n++;
    end
    check("ch3_commit_latency", PW'(n), PW'(11));
    pulses = 0;
    for (int k = 0; k < 64; k++) begin
      idle();
      if (period) pulses++;
    end
    check("period_pulses_64", PW'(pulses), PW'(4));

    // Shadow rewrites while pending; a write in the commit cycle stays in shadow.
    for (int k = 0; k < 64 && m_ctr != 2; k++) idle();
    wr(32'h000, 32'h3);
    wr(32'h014, 32'h11);
    wr(32'h014, 32'h22);
    for (int k = 0; k < 64 && m_ctr != 15; k++) idle();
    wr(32'h014, 32'h33);
    check("ch1_gets_22", PW'(pulse_width[15:8]), PW'(8'h22));
    rd(32'h014, r);
    check("ch1_shadow_33", PW'(r), PW'(32'h33));
    // UPD in the commit cycle keeps pending set for the next boundary.
    wr(32'h000, 32'h3);
    for (int k = 0; k < 64 && m_ctr != 15; k++) idle();
    wr(32'h000, 32'h3);
    check("ch1_gets_33", PW'(pulse_width[15:8]), PW'(8'h33));
    rd(32'h000, r);
    check("ctrl_repend", PW'(r), PW'(32'h3));
    for (int k = 0; k < 64 && m_ctr != 15; k++) idle();
    idle();
    rd(32'h000, r);
    check("ctrl_cleared", PW'(r), PW'(32'h1));

    // Asynchronous reset mid-period with pending set.
    wr(32'h000, 32'h3);
    rd(32'h01C, r);
    rst = 1'b1;
    #2;
    check_all_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd(32'h000, r);
    check("post_rst_ctrl", PW'(r), '0);
    rd(32'h00C, r);
    check("post_rst_maxact", PW'(r), '0);
    rd(32'h01C, r);
    check("post_rst_width3", PW'(r), '0);

    // MAX_ACT=0: every cycle is a boundary.
    wr(32'h000, 32'h1);
    repeat (3) begin
      idle();
      check("period_max0", PW'(period), PW'(1'b1));
    end

    // Random traffic against the model.
    for (int t = 0; t < 800; t++) begin
      sel   = int'($urandom_range(0, 9));
      rwe   = 1'($urandom_range(0, 1));
      be    = 4'($urandom_range(0, 15));
      wdata = $urandom;
      tmp   = $urandom;
      case (sel)
        0, 1: begin
          off = 12'h000;
          wdata[0] = ($urandom_range(0, 3) != 0);
        end
        2: begin
          off = 12'h004;
          wdata[7:0] = 8'($urandom_range(0, 5));
        end
        3: off = 12'h008;
        4: off = 12'h00C;
        8: off = 12'(4 * $urandom_range(4 + NumCh, 1023));
        default: off = 12'(16 + 4 * $urandom_range(0, NumCh - 1));
      endcase
      addr = {tmp[31:12], off[11:2], tmp[1:0]};
      if (sel == 9) idle();
      else cycle(1, rwe, addr, wdata, be, r, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
